// File: rtl/matrix_multiplier.sv
// matrix_multiplier: sequential signed C = A x B for square N x N operands.
// A and B live in internal register files loaded through write ports; a start
// pulse runs one multiply-accumulate per cycle (i outer, j middle, k inner);
// C is read back combinationally.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | operand writes accepted, waiting for start
// CALC    | one MAC per edge; C[i][j] written on its k = N-1 edge
// DONE    | one-cycle completion pulse, then back to IDLE
module matrix_multiplier #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = $clog2(N*N),
    parameter int CW = 2*DW + $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 a_we_i,
    input  logic [AW-1:0]        a_addr_i,
    input  logic signed [DW-1:0] a_data_i,
    input  logic                 b_we_i,
    input  logic [AW-1:0]        b_addr_i,
    input  logic signed [DW-1:0] b_data_i,
    input  logic [AW-1:0]        c_addr_i,
    output logic signed [CW-1:0] c_data_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int NN = N*N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [CW-1:0] acc_q, acc_d;

    logic signed [DW-1:0] a_q [NN];
    logic signed [DW-1:0] b_q [NN];
    logic signed [CW-1:0] c_q [NN];

    logic [AW-1:0]          a_idx, b_idx, c_idx;
    logic signed [2*DW-1:0] prod;
    logic signed [CW-1:0]   sum;
    logic                   c_we;

    // Operand addressing and the full-precision MAC datapath
    always_comb begin
        a_idx = AW'(i_q) * AW'(N) + AW'(k_q);
        b_idx = AW'(k_q) * AW'(N) + AW'(j_q);
        c_idx = AW'(i_q) * AW'(N) + AW'(j_q);
        prod  = a_q[a_idx] * b_q[b_idx];
        sum   = acc_q + CW'(prod);
    end

    // Next-state logic: loop counters, accumulator and C write strobe
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        acc_d   = acc_q;
        c_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_CALC;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    acc_d   = '0;
                end
            end
            ST_CALC: begin
                if (k_q == IW'(N-1)) begin
                    c_we  = 1'b1;
                    acc_d = '0;
                    k_d   = '0;
                    if (j_q == IW'(N-1)) begin
                        j_d = '0;
                        if (i_q == IW'(N-1)) begin
                            i_d     = '0;
                            state_d = ST_DONE;
                        end else begin
                            i_d = i_q + IW'(1);
                        end
                    end else begin
                        j_d = j_q + IW'(1);
                    end
                end else begin
                    acc_d = sum;
                    k_d   = k_q + IW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
        end
    end

    // Operand files: defaults A = 1..N*N row-major, B = 2*I; writes only in IDLE
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NN; n++) begin
                a_q[n] <= DW'(n + 1);
                b_q[n] <= ((n / N) == (n % N)) ? DW'(2) : '0;
            end
        end else if (state_q == ST_IDLE) begin
            if (a_we_i && (32'(a_addr_i) < NN)) begin
                a_q[a_addr_i] <= a_data_i;
            end
            if (b_we_i && (32'(b_addr_i) < NN)) begin
                b_q[b_addr_i] <= b_data_i;
            end
        end
    end

    // Result file: each element updated on the edge finishing its dot product
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int n = 0; n < NN; n++) begin
                c_q[n] <= '0;
            end
        end else if (c_we) begin
            c_q[c_idx] <= sum;
        end
    end

    assign c_data_o = (32'(c_addr_i) < NN) ? c_q[c_addr_i] : '0;
    assign busy_o   = (state_q == ST_CALC);
    assign done_o   = (state_q == ST_DONE);

endmodule

// File: tb/tb_matrix_multiplier.sv
// Self-checking bench for matrix_multiplier (N=3, DW=8): table-driven operand
// vectors plus hand-written protocol, reset and range sequences; expected C
// values are queued when a computation is launched and drained after done.
module tb_matrix_multiplier;

    logic        clk = 1'b0;
    logic        rst_n, start, a_we, b_we;
    logic [3:0]  a_addr, b_addr, c_addr;
    logic [7:0]  a_data, b_data;
    logic [17:0] c_data;
    logic        busy, done;

    matrix_multiplier dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start),
        .a_we_i   (a_we),
        .a_addr_i (a_addr),
        .a_data_i (a_data),
        .b_we_i   (b_we),
        .b_addr_i (b_addr),
        .b_data_i (b_data),
        .c_addr_i (c_addr),
        .c_data_o (c_data),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    typedef struct packed {
        logic [8:0][7:0]  a;
        logic [8:0][7:0]  b;
        logic [8:0][31:0] c;
    } vec_t;
    vec_t vecs[4];

    int ma[9], mb[9], exp_c[9];
    int a1[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int b1[9] = '{9, 8, 7, 6, 5, 4, 3, 2, 1};
    int c1[9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};
    int lat, extra_done, extra_busy;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic compute_model();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++) s += ma[i*3+k] * mb[k*3+j];
                exp_c[i*3+j] = s;
            end
        end
    endtask

    task automatic set_default_expect();
        for (int n = 0; n < 9; n++) exp_c[n] = 2 * (n + 1);
    endtask

    task automatic load_ab();
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            a_we = 1'b1; b_we = 1'b1;
            a_addr = 4'(n); b_addr = 4'(n);
            a_data = 8'(ma[n]); b_data = 8'(mb[n]);
        end
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic push_expected();
        sb_t e;
        for (int n = 0; n < 9; n++) begin
            e.addr = 4'(n);
            e.val  = 32'(exp_c[n]);
            sb_q.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            c_addr = e.addr;
            #1;
            check($sformatf("%s_c%0d", tag, e.addr), $signed(c_data), $signed(e.val));
        end
    endtask

    task automatic wait_done();
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Launch (optionally with a same-cycle A write), wait for done, check timing and C
    task automatic run(input string tag, input logic wr, input logic [3:0] waddr,
                       input logic [7:0] wdata);
        push_expected();
        @(negedge clk);
        start = 1'b1; a_we = wr; a_addr = waddr; a_data = wdata;
        @(negedge clk);
        start = 1'b0; a_we = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        lat = 0;
        wait_done();
        check({tag, "_done_latency"}, lat, 27);
        check({tag, "_busy_in_done"}, busy, 0);
        @(negedge clk);
        check({tag, "_done_width"}, done, 0);
        check({tag, "_busy_after"}, busy, 0);
        drain(tag);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; a_we = 1'b0; b_we = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; c_addr = '0;
        lat = 0; extra_done = 0; extra_busy = 0;

        for (int n = 0; n < 9; n++) begin
            vecs[0].a[n] = 8'(a1[n]);
            vecs[0].b[n] = 8'(b1[n]);
            vecs[0].c[n] = 32'(c1[n]);
            vecs[1].a[n] = 8'h80;
            vecs[1].b[n] = 8'h80;
            vecs[1].c[n] = 32'(49152);
            vecs[2].a[n] = 8'h80;
            vecs[2].b[n] = 8'd127;
            vecs[2].c[n] = 32'(-48768);
        end
        for (int n = 0; n < 9; n++) begin
            ma[n] = $signed(8'($urandom_range(255)));
            mb[n] = $signed(8'($urandom_range(255)));
        end
        compute_model();
        for (int n = 0; n < 9; n++) begin
            vecs[3].a[n] = 8'(ma[n]);
            vecs[3].b[n] = 8'(mb[n]);
            vecs[3].c[n] = 32'(exp_c[n]);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        for (int n = 0; n < 9; n++) begin
            c_addr = 4'(n);
            #1;
            check($sformatf("rst_c%0d", n), $signed(c_data), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Default operands: A = 1..9, B = 2*I
        set_default_expect();
        run("dflt", 1'b0, 4'd0, 8'd0);

        // Table-driven loaded operands
        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < 9; n++) begin
                ma[n]    = $signed(vecs[v].a[n]);
                mb[n]    = $signed(vecs[v].b[n]);
                exp_c[n] = $signed(vecs[v].c[n]);
            end
            load_ab();
            run($sformatf("vec%0d", v), 1'b0, 4'd0, 8'd0);
        end

        // Write and start during CALC are ignored
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        repeat (5) begin
            @(negedge clk);
            lat++;
        end
        a_we = 1'b1; a_addr = 4'd0; a_data = 8'd99; start = 1'b1;
        @(negedge clk);
        lat++;
        a_we = 1'b0; start = 1'b0;
        wait_done();
        check("proto_done_latency", lat, 27);
        check("proto_busy_in_done", busy, 0);
        repeat (35) begin
            @(negedge clk);
            if (done) extra_done++;
            if (busy) extra_busy++;
        end
        check("proto_extra_done", extra_done, 0);
        check("proto_extra_busy", extra_busy, 0);
        drain("proto");

        // Asynchronous reset at MAC cycle 10
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        for (int n = 0; n < 9; n++) begin
            c_addr = 4'(n);
            #0.1;
            check($sformatf("midrst_c%0d", n), $signed(c_data), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_default_expect();
        run("rst_dflt", 1'b0, 4'd0, 8'd0);

        // Out-of-range write and read
        @(negedge clk);
        a_we = 1'b1; a_addr = 4'd9; a_data = 8'd5;
        b_we = 1'b1; b_addr = 4'd9; b_data = 8'd7;
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;
        c_addr = 4'd15;
        #1;
        check("oor_read", $signed(c_data), 0);
        set_default_expect();
        run("oor", 1'b0, 4'd0, 8'd0);

        // Write and start in the same IDLE cycle: new A[0][0] = 10 is used
        set_default_expect();
        exp_c[0] = 20;
        run("wr_start", 1'b1, 4'd0, 8'd10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
